// File: rtl/adder_pkg.sv
// Shared arithmetic-path definitions: FSM state encoding and default operand width.
package adder_pkg;

    localparam int ADD_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add8_if.sv
// Start/done handshake and operand/result bus between the operand sequencer and the adder.
interface serial_add8_if
    import adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   sum;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum
    );
endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell reused by the bit-serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add8.sv
// Bit-serial adder: one full_adder cell and a registered carry produce A+B+CIN
// LSB-first over WIDTH cycles, with a start/busy/done handshake.
module serial_add8
    import adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    serial_add8_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum_r;
    logic             fa_s;
    logic             fa_co;
    logic             accept;

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_s),
        .cout (fa_co)
    );

    // start is only honoured outside SHIFT so in-flight operands stay intact
    always_comb begin
        accept     = 1'b0;
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = SHIFT;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                a_sr   <= bus.a;
                b_sr   <= bus.b;
                carry  <= bus.cin;
                cnt    <= '0;
                res_sr <= '0;
            end else if (state == SHIFT) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                res_sr <= {fa_s, res_sr[WIDTH-1:1]};
                carry  <= fa_co;
                cnt    <= cnt + 1'b1;
                // The final bit and carry-out bypass res_sr so sum is ready at DONE
                if (cnt == LAST) begin
                    sum_r <= {fa_co, fa_s, res_sr[WIDTH-1:1]};
                end
            end
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_r;

endmodule

// File: tb/tb_serial_add8.sv
// Randomized and directed bench for serial_add8 with a queue-based scoreboard
// checking result value and latency whenever done is presented.
module tb_serial_add8;
    localparam int W = 8;

    typedef struct {
        int sum;
        int cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   vectors;
    int   miscompares;
    int   last_sum;
    logic prev_done;
    exp_t exp_q[$];

    serial_add8_if #(.WIDTH(W)) bus ();

    serial_add8 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drive one request at the current time and record its expected completion
    task automatic applyStimulus(input int av, input int bv, input int cv);
        exp_t e;
        bus.start = 1'b1;
        bus.a     = av[W-1:0];
        bus.b     = bv[W-1:0];
        bus.cin   = cv[0];
        e.sum     = av + bv + cv;
        e.cyc     = cyc + W + 1;
        exp_q.push_back(e);
    endtask

    task automatic waitDone(output int busy_cnt);
        bit found;
        busy_cnt = 0;
        found    = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) found = 1'b1;
            else if (bus.busy) busy_cnt++;
        end
        if (!found) checkOutput("done_timeout", 0, 1);
    endtask

    // Scoreboard monitor: pops one expected result for each done pulse
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            checkOutput("done_width", int'(prev_done), 0);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("sum", int'(bus.sum), e.sum);
                checkOutput("latency", cyc, e.cyc);
                last_sum = e.sum;
            end
        end
        prev_done <= bus.done;
    end

    initial begin
        int bc;
        cyc         = 0;
        vectors     = 0;
        miscompares = 0;
        last_sum    = 0;
        prev_done   = 1'b0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        bus.cin     = 1'b0;

        #12;
        checkOutput("reset_busy", int'(bus.busy), 0);
        checkOutput("reset_done", int'(bus.done), 0);
        checkOutput("reset_sum", int'(bus.sum), 0);
        @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        applyStimulus(100, 27, 0);
        waitDone(bc);
        checkOutput("busy_cycles", bc, W);

        @(negedge clk);
        applyStimulus(255, 255, 1);
        waitDone(bc);
        checkOutput("carry_out", int'(bus.sum[W]), 1);

        @(negedge clk);
        applyStimulus(0, 0, 0);
        waitDone(bc);

        // A second start during SHIFT must be ignored
        @(negedge clk);
        applyStimulus(10, 20, 0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'd200;
        bus.b     = 8'd200;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(bc);
        repeat (10) @(negedge clk);
        checkOutput("ignored_start_sum", int'(bus.sum), 30);

        // Reset mid-operation clears everything immediately and drops the request
        applyStimulus(50, 60, 0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("midrst_busy", int'(bus.busy), 0);
        checkOutput("midrst_done", int'(bus.done), 0);
        checkOutput("midrst_sum", int'(bus.sum), 0);
        exp_q.delete();
        last_sum = 0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 2, 1);
        waitDone(bc);
        checkOutput("post_reset_busy", bc, W);

        // Back-to-back issue on the done cycle
        @(negedge clk);
        applyStimulus(3, 4, 0);
        waitDone(bc);
        applyStimulus(7, 8, 1);
        waitDone(bc);
        checkOutput("b2b_busy", bc, W);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 1)));
            waitDone(bc);
        end

        repeat (5) @(negedge clk);
        checkOutput("sum_hold", int'(bus.sum), last_sum);
        checkOutput("idle_done", int'(bus.done), 0);
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
